// File: rtl/spi_master_mmio_pkg.sv
// Shared definitions for the memory-mapped SPI master: register offsets,
// STATUS/CTRL bit positions and the shift engine state encoding.
package spi_master_mmio_pkg;

    // Word offsets inside the 16-byte register window
    localparam logic [3:0] REG_STATUS = 4'h0;
    localparam logic [3:0] REG_DATA   = 4'h4;
    localparam logic [3:0] REG_DIV    = 4'h8;

    // STATUS read bit positions
    localparam int STAT_BUSY     = 0;
    localparam int STAT_RX_NE    = 1;
    localparam int STAT_TX_FULL  = 2;
    localparam int STAT_CS_ACT   = 3;
    localparam int STAT_TX_OVF   = 4;
    localparam int STAT_RX_OVF   = 5;
    localparam int STAT_IE       = 6;

    // CTRL write bit positions (4 and 5 are write-1-to-clear for the flags)
    localparam int CTRL_CS       = 0;
    localparam int CTRL_CLR_TX   = 4;
    localparam int CTRL_CLR_RX   = 5;
    localparam int CTRL_IE       = 6;

    // Shift engine states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_LOW  = 2'd2,
        S_HIGH = 2'd3
    } spi_state_t;

endpackage

// File: rtl/mmio_byte_fifo.sv
// Byte-wide synchronous FIFO with occupancy counter. A pop and a push in the
// same cycle are both honoured when full (the pop frees the slot) and only
// the push takes effect when empty.
module mmio_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       r_clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge r_clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates every read
    always_ff @(posedge r_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/spi_master_mmio.sv
// SPI master (mode 0, MSB first) behind the picorv32 native memory bus.
// Firmware queues bytes into an 8-deep TX FIFO; the shift engine clocks them
// out while chip select is asserted and collects received bytes in an RX FIFO.
module spi_master_mmio #(
    parameter logic [31:0] BASE_ADDR  = 32'h0100_0100,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [7:0]  DIV_RESET  = 8'd4
) (
    input  logic        r_clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        cs_n,
    output logic        irq
);

    import spi_master_mmio_pkg::*;

    // Bus decode
    logic        sel;
    logic        act;
    logic        wr;
    logic        rd;
    logic [3:0]  reg_off;
    logic        ctrl_wr;
    logic        div_wr;

    // Control and status state
    logic        cs_req;
    logic        cs_req_next;
    logic        cs_active;
    logic        ie;
    logic        tx_ovf;
    logic        rx_ovf;
    logic [7:0]  div_reg;
    logic [31:0] status;
    logic [31:0] rd_word;

    // FIFO interfaces
    logic        tx_push;
    logic        tx_pop;
    logic [7:0]  tx_dout;
    logic        tx_full;
    logic        tx_empty;
    logic        tx_drop;
    logic        rx_push;
    logic        rx_pop;
    logic [7:0]  rx_dout;
    logic        rx_full;
    logic        rx_empty;
    logic        rx_drop;

    // Shift engine
    spi_state_t  state;
    logic [7:0]  shreg;
    logic [2:0]  bitcnt;
    logic [7:0]  divcnt;
    logic [7:0]  div_reload;

    logic        unused_bits;
    assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:8]};

    // A request is acted on once; the cycle that carries mem_ready is dead
    assign sel     = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign act     = sel && !mem_ready;
    assign wr      = act && (mem_wstrb != 4'b0000);
    assign rd      = act && (mem_wstrb == 4'b0000);
    assign reg_off = {mem_addr[3:2], 2'b00};
    assign ctrl_wr = wr && (reg_off == REG_STATUS);
    assign div_wr  = wr && (reg_off == REG_DIV);

    assign cs_active   = !cs_n;
    assign cs_req_next = ctrl_wr ? mem_wdata[CTRL_CS] : cs_req;
    assign div_reload  = div_reg - 8'd1;

    // FIFO handshakes; a drop only happens when no pop frees a slot this cycle
    assign tx_push = wr && (reg_off == REG_DATA);
    assign tx_pop  = (state == S_IDLE) && !tx_empty && cs_req && cs_active;
    assign tx_drop = tx_push && tx_full && !tx_pop;
    assign rx_pop  = rd && (reg_off == REG_DATA) && !rx_empty;
    assign rx_push = (state == S_HIGH) && (divcnt == 8'd0) && (bitcnt == 3'd0);
    assign rx_drop = rx_push && rx_full && !rx_pop;

    assign irq = ie && !rx_empty;

    mmio_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .r_clk (r_clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (mem_wdata[7:0]),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    mmio_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .r_clk (r_clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (shreg),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Assemble the STATUS word from live state
    always_comb begin
        status               = '0;
        status[STAT_BUSY]    = (state != S_IDLE) || !tx_empty;
        status[STAT_RX_NE]   = !rx_empty;
        status[STAT_TX_FULL] = tx_full;
        status[STAT_CS_ACT]  = cs_active;
        status[STAT_TX_OVF]  = tx_ovf;
        status[STAT_RX_OVF]  = rx_ovf;
        status[STAT_IE]      = ie;
    end

    // Read data selection; an empty RX FIFO reads as all ones
    always_comb begin
        rd_word = '0;
        case (reg_off)
            REG_STATUS: rd_word = status;
            REG_DATA:   rd_word = rx_empty ? 32'hFFFF_FFFF : {24'h0, rx_dout};
            REG_DIV:    rd_word = {24'h0, div_reg};
            default:    rd_word = '0;
        endcase
    end

    // Bus acknowledge and registered read data
    always_ff @(posedge r_clk) begin
        if (!rst_n) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_ready <= act;
            mem_rdata <= rd ? rd_word : 32'h0;
        end
    end

    // Control register, sticky flags, divider and chip select
    always_ff @(posedge r_clk) begin
        if (!rst_n) begin
            cs_req  <= 1'b0;
            ie      <= 1'b0;
            tx_ovf  <= 1'b0;
            rx_ovf  <= 1'b0;
            div_reg <= DIV_RESET;
            cs_n    <= 1'b1;
        end else begin
            cs_req <= cs_req_next;
            if (ctrl_wr) begin
                ie <= mem_wdata[CTRL_IE];
            end
            if (tx_drop) begin
                tx_ovf <= 1'b1;
            end else if (ctrl_wr && mem_wdata[CTRL_CLR_TX]) begin
                tx_ovf <= 1'b0;
            end
            if (rx_drop) begin
                rx_ovf <= 1'b1;
            end else if (ctrl_wr && mem_wdata[CTRL_CLR_RX]) begin
                rx_ovf <= 1'b0;
            end
            if (div_wr) begin
                div_reg <= (mem_wdata[7:0] == 8'd0) ? 8'd1 : mem_wdata[7:0];
            end
            // Releasing chip select waits for the engine to finish its byte
            cs_n <= !(cs_req_next || (cs_active && (state != S_IDLE)));
        end
    end

    // Shift engine: one byte per pop, sample on rising SCLK, shift on falling
    always_ff @(posedge r_clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            sclk   <= 1'b0;
            mosi   <= 1'b0;
            bitcnt <= 3'd0;
            divcnt <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (tx_pop) begin
                        shreg <= tx_dout;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    mosi   <= shreg[7];
                    bitcnt <= 3'd7;
                    divcnt <= div_reload;
                    state  <= S_LOW;
                end
                S_LOW: begin
                    if (divcnt == 8'd0) begin
                        sclk   <= 1'b1;
                        shreg  <= {shreg[6:0], miso};
                        divcnt <= div_reload;
                        state  <= S_HIGH;
                    end else begin
                        divcnt <= divcnt - 8'd1;
                    end
                end
                S_HIGH: begin
                    if (divcnt == 8'd0) begin
                        sclk <= 1'b0;
                        if (bitcnt == 3'd0) begin
                            state <= S_IDLE;
                        end else begin
                            mosi   <= shreg[7];
                            bitcnt <= bitcnt - 3'd1;
                            divcnt <= div_reload;
                            state  <= S_LOW;
                        end
                    end else begin
                        divcnt <= divcnt - 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
